itrx_aib_phy_redn_nch_ctrl: RTL and testbench

ITRX_AIB_PHY_REDN_NCH_CTRL -- requirements
Module: itrx_aib_phy_redn_nch_ctrl

---
 rtl/itrx_aib_phy_redn_pkg.sv | 23 ++
 rtl/itrx_aib_phy_redn_sel.sv | 43 ++++
 rtl/itrx_aib_phy_redn_nch_ctrl.sv | 159 +++++++++++++++
 tb/tb_itrx_aib_phy_redn_nch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/itrx_aib_phy_redn_pkg.sv
// Shared definitions for the AIB PHY redundancy controller.
// Holds the controller FSM state encoding and a constant-evaluable ceil(log2) helper used to
// size index and counter fields.
package itrx_aib_phy_redn_pkg;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHold = 1'b1
  } redn_st_e;

  // Smallest n such that 2**n >= val; returns 0 for val <= 1.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/itrx_aib_phy_redn_sel.sv
// Per-IO source select for the redundancy shifter.
// One instance drives AIB IO K from the functional data of channel K, of channel K-1, or from
// the BSR (jtag) bit, depending on whether repair is engaged and where K sits relative to the
// failed IO.
//   redn_en_i   : repair engaged in the active map
//   fail_idx_i  : failed IO index of the active map
//   jtag_i      : BSR data for this IO
//   nrml_cur_i  : functional data of channel K (unused for the spare IO)
//   nrml_prv_i  : functional data of channel K-1 (unused for IO 0)
//   io_o        : selected data for this IO
module itrx_aib_phy_redn_sel #(
  parameter int unsigned K    = 0,
  parameter int unsigned NCH  = 4,
  parameter int unsigned DWID = 1,
  parameter int unsigned IDXW = 2
) (
  input  logic            redn_en_i,
  input  logic [IDXW-1:0] fail_idx_i,
  input  logic [DWID-1:0] jtag_i,
  input  logic [DWID-1:0] nrml_cur_i,
  input  logic [DWID-1:0] nrml_prv_i,
  output logic [DWID-1:0] io_o
);

  logic [31:0] fidx;
  assign fidx = 32'(fail_idx_i);

  always_comb begin
    io_o = jtag_i;
    if (!redn_en_i) begin
      // Without repair the spare IO carries its BSR bit.
      io_o = (K < NCH) ? nrml_cur_i : jtag_i;
    end else if (K < fidx) begin
      io_o = nrml_cur_i;
    end else if (K == fidx) begin
      io_o = jtag_i;
    end else begin
      // Channels above the failed IO shift up by one, the last one landing on the spare.
      io_o = nrml_prv_i;
    end
  end

endmodule

// File: rtl/itrx_aib_phy_redn_nch_ctrl.sv
// AIB PHY N-channel redundancy controller.
// Accepts repair configurations, freezes the IO outputs for HOLD_CYC cycles while a new map is
// swapped in, and registers the per-IO selected data onto the AIB IOs. jtag_mode overrides both
// the map and the freeze.
//   clk, rst_n              : clock, asynchronous active-low reset
//   jtag_mode               : drive every IO from jtag_di
//   nrml_di                 : functional data, channel i at [i*DWID +: DWID]
//   jtag_di                 : BSR data per IO, spare included
//   cfg_valid/cfg_ready     : repair config handshake
//   cfg_fail_en/cfg_fail_idx: engage/release repair and failed IO index
//   cfg_err                 : one-cycle pulse on a rejected config
//   redn_active/active_idx  : active map
//   mux_do                  : registered data to the AIB IOs
module itrx_aib_phy_redn_nch_ctrl
  import itrx_aib_phy_redn_pkg::*;
#(
  parameter  int unsigned NCH      = 4,
  parameter  int unsigned DWID     = 1,
  parameter  int unsigned HOLD_CYC = 4,
  localparam int unsigned IDXW     = clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jtag_mode,
  input  logic [NCH*DWID-1:0]   nrml_di,
  input  logic [(NCH+1)*DWID-1:0] jtag_di,
  input  logic                  cfg_valid,
  input  logic                  cfg_fail_en,
  input  logic [IDXW-1:0]       cfg_fail_idx,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic                  redn_active,
  output logic [IDXW-1:0]       active_idx,
  output logic [(NCH+1)*DWID-1:0] mux_do
);

  localparam int unsigned CNTW = (clog2(HOLD_CYC) > 0) ? clog2(HOLD_CYC) : 1;
  localparam int unsigned IOW  = (NCH + 1) * DWID;

  redn_st_e        state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pend_en_q, pend_en_d;
  logic [IDXW-1:0] pend_idx_q, pend_idx_d;
  logic            act_en_q, act_en_d;
  logic [IDXW-1:0] act_idx_q, act_idx_d;
  logic            err_q, err_d;
  logic [IOW-1:0]  mux_q, mux_d;
  logic [IOW-1:0]  sel_do;
  logic            accept;
  logic            idx_bad;

  for (genvar k = 0; k <= NCH; k++) begin : g_io
    logic [DWID-1:0] nrml_cur;
    logic [DWID-1:0] nrml_prv;

    if (k < NCH) begin : g_cur
      assign nrml_cur = nrml_di[k*DWID +: DWID];
    end else begin : g_cur_spare
      assign nrml_cur = '0;
    end

    if (k > 0) begin : g_prv
      assign nrml_prv = nrml_di[(k-1)*DWID +: DWID];
    end else begin : g_prv_first
      assign nrml_prv = '0;
    end

    itrx_aib_phy_redn_sel #(
      .K    (k),
      .NCH  (NCH),
      .DWID (DWID),
      .IDXW (IDXW)
    ) u_sel (
      .redn_en_i  (act_en_q),
      .fail_idx_i (act_idx_q),
      .jtag_i     (jtag_di[k*DWID +: DWID]),
      .nrml_cur_i (nrml_cur),
      .nrml_prv_i (nrml_prv),
      .io_o       (sel_do[k*DWID +: DWID])
    );
  end

  assign accept  = cfg_valid && (state_q == StRun);
  // Only an engage request can name a nonexistent IO; a release ignores the index.
  assign idx_bad = cfg_fail_en && (32'(cfg_fail_idx) >= NCH);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_en_d  = pend_en_q;
    pend_idx_d = pend_idx_q;
    act_en_d   = act_en_q;
    act_idx_d  = act_idx_q;
    err_d      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (idx_bad) begin
            err_d = 1'b1;
          end else begin
            pend_en_d  = cfg_fail_en;
            pend_idx_d = cfg_fail_idx;
            cnt_d      = CNTW'(HOLD_CYC - 1);
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          act_en_d  = pend_en_q;
          act_idx_d = pend_idx_q;
          state_d   = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    if (jtag_mode) begin
      mux_d = jtag_di;
    end else if (state_q == StHold) begin
      mux_d = mux_q;
    end else begin
      mux_d = sel_do;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      pend_en_q  <= 1'b0;
      pend_idx_q <= '0;
      act_en_q   <= 1'b0;
      act_idx_q  <= '0;
      err_q      <= 1'b0;
      mux_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_en_q  <= pend_en_d;
      pend_idx_q <= pend_idx_d;
      act_en_q   <= act_en_d;
      act_idx_q  <= act_idx_d;
      err_q      <= err_d;
      mux_q      <= mux_d;
    end
  end

  assign cfg_ready   = (state_q == StRun);
  assign cfg_err     = err_q;
  assign redn_active = act_en_q;
  assign active_idx  = act_idx_q;
  assign mux_do      = mux_q;

endmodule

// File: tb/tb_itrx_aib_phy_redn_nch_ctrl.sv
// Self-checking bench for itrx_aib_phy_redn_nch_ctrl: directed scenarios plus random traffic on
// an NCH=4 instance against a schedule-based reference model, and directed error checks on an
// NCH=5 instance.
module tb_itrx_aib_phy_redn_nch_ctrl;

  localparam int NCH  = 4;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  always #5 clk = ~clk;

  // NCH=4 instance
  logic       jtag_mode = 1'b0;
  logic [3:0] nrml_di = '0;
  logic [4:0] jtag_di = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_fail_en = 1'b0;
  logic [1:0] cfg_fail_idx = '0;
  logic       cfg_ready, cfg_err, redn_active;
  logic [1:0] active_idx;
  logic [4:0] mux_do;

  // NCH=5 instance
  logic       jm5 = 1'b0;
  logic [4:0] nrml5 = '0;
  logic [5:0] jtag5 = '0;
  logic       v5 = 1'b0;
  logic       en5 = 1'b0;
  logic [2:0] idx5 = '0;
  logic       rdy5, err5, ra5;
  logic [2:0] aidx5;
  logic [5:0] mux5;

  itrx_aib_phy_redn_nch_ctrl #(.NCH(4), .DWID(1), .HOLD_CYC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jtag_mode    (jtag_mode),
    .nrml_di      (nrml_di),
    .jtag_di      (jtag_di),
    .cfg_valid    (cfg_valid),
    .cfg_fail_en  (cfg_fail_en),
    .cfg_fail_idx (cfg_fail_idx),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .redn_active  (redn_active),
    .active_idx   (active_idx),
    .mux_do       (mux_do)
  );

  itrx_aib_phy_redn_nch_ctrl #(.NCH(5), .DWID(1), .HOLD_CYC(4)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .jtag_mode    (jm5),
    .nrml_di      (nrml5),
    .jtag_di      (jtag5),
    .cfg_valid    (v5),
    .cfg_fail_en  (en5),
    .cfg_fail_idx (idx5),
    .cfg_ready    (rdy5),
    .cfg_err      (err5),
    .redn_active  (ra5),
    .active_idx   (aidx5),
    .mux_do       (mux5)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: active/pending maps plus the edge number of the last accepted config.
  logic [4:0] m_mux;
  bit         m_act_en, m_pend_en, m_busy, m_err;
  int         m_act_idx, m_pend_idx, acc_edge, edge_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // IO mapping straight from the channel-shift rule.
  function automatic logic [4:0] ref_map(input bit en, input int f, input logic [3:0] n,
                                         input logic [4:0] j);
    logic [4:0] r;
    for (int k = 0; k <= NCH; k++) begin
      if (!en)        r[k] = (k < NCH) ? n[k] : j[NCH];
      else if (k < f) r[k] = n[k];
      else if (k == f) r[k] = j[k];
      else            r[k] = n[k-1];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mux = '0; m_act_en = 0; m_act_idx = 0; m_pend_en = 0; m_pend_idx = 0;
    m_busy = 0; m_err = 0;
  endtask

  task automatic model_edge();
    edge_n++;
    if (jtag_mode)   m_mux = jtag_di;
    else if (!m_busy) m_mux = ref_map(m_act_en, m_act_idx, nrml_di, jtag_di);
    m_err = 0;
    if (m_busy) begin
      if (edge_n == acc_edge + HOLD) begin
        m_act_en = m_pend_en; m_act_idx = m_pend_idx; m_busy = 0;
      end
    end else if (cfg_valid) begin
      if (cfg_fail_en && int'(cfg_fail_idx) >= NCH) m_err = 1;
      else begin
        m_pend_en = cfg_fail_en; m_pend_idx = int'(cfg_fail_idx);
        m_busy = 1; acc_edge = edge_n;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mux"},   64'(mux_do), 64'(m_mux));
    chk({tag, ".ready"}, 64'(cfg_ready), 64'(!m_busy));
    chk({tag, ".redn"},  64'(redn_active), 64'(m_act_en));
    chk({tag, ".idx"},   64'(active_idx), 64'(m_act_idx));
    chk({tag, ".err"},   64'(cfg_err), 64'(m_err));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic cfg(input bit en, input int idx, input string tag);
    cfg_valid = 1'b1; cfg_fail_en = en; cfg_fail_idx = 2'(idx);
    cycle(tag);
    cfg_valid = 1'b0;
  endtask

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".mux5"}, 64'(mux5), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    edge_n = 0; acc_edge = 0;
    model_reset();
    #2;
    @(negedge clk);
    do_reset("por");

    // Basic path, no repair
    nrml_di = 4'hA; jtag_di = 5'h10;
    cycle("basic");
    chk("basic.const", 64'(mux_do), 64'h1A);

    // Engage repair at IO 1
    nrml_di = 4'b1011; jtag_di = 5'h00;
    cfg(1, 1, "eng1.acc");
    repeat (HOLD) cycle("eng1.hold");
    chk("eng1.redn", 64'(redn_active), 64'd1);
    cycle("eng1.new");
    chk("eng1.const", 64'(mux_do), 64'b10101);
    chk("eng1.aidx", 64'(active_idx), 64'd1);

    // Identical map reruns the full hold
    nrml_di = 4'b0101;
    cfg(1, 1, "same.acc");
    repeat (HOLD) cycle("same.hold");
    cycle("same.new");

    // jtag override mid-hold, hold still ends on schedule
    cfg(1, 2, "jt.acc");
    cycle("jt.h1");
    jtag_mode = 1'b1; jtag_di = 5'h15;
    cycle("jt.h2");
    chk("jt.const", 64'(mux_do), 64'h15);
    jtag_mode = 1'b0; jtag_di = 5'h00; nrml_di = 4'b1110;
    cycle("jt.h3");
    cycle("jt.h4");
    chk("jt.frozen", 64'(mux_do), 64'h15);
    chk("jt.aidx", 64'(active_idx), 64'd2);
    cycle("jt.new");

    // Reset in the second hold cycle discards the pending map
    cfg(0, 0, "rst.acc");
    cycle("rst.h1");
    do_reset("rst.mid");
    cycle("rst.after");
    chk("rst.ready", 64'(cfg_ready), 64'd1);
    chk("rst.redn", 64'(redn_active), 64'd0);

    // NCH=5: out-of-range engage indices are rejected without freezing
    nrml5 = 5'b10110; jtag5 = 6'b100000; v5 = 1'b1; en5 = 1'b1; idx5 = 3'd6;
    cycle("n5.bad6");
    chk("n5.err6", 64'(err5), 64'd1);
    chk("n5.rdy6", 64'(rdy5), 64'd1);
    chk("n5.ra6", 64'(ra5), 64'd0);
    chk("n5.mux6", 64'(mux5), 64'b110110);
    v5 = 1'b0; nrml5 = 5'b01001;
    cycle("n5.after6");
    chk("n5.errclr", 64'(err5), 64'd0);
    chk("n5.nofrz", 64'(mux5), 64'b101001);
    v5 = 1'b1; idx5 = 3'd5;
    cycle("n5.bad5");
    chk("n5.err5", 64'(err5), 64'd1);
    v5 = 1'b1; idx5 = 3'd4;
    cycle("n5.ok4");
    chk("n5.err4", 64'(err5), 64'd0);
    chk("n5.rdy4", 64'(rdy5), 64'd0);
    v5 = 1'b0;
    repeat (HOLD) cycle("n5.hold");
    chk("n5.ra4", 64'(ra5), 64'd1);
    chk("n5.aidx4", 64'(aidx5), 64'd4);
    cycle("n5.new");
    chk("n5.map4", 64'(mux5), 64'b001001);

    // Engage at IO 3, then release
    cfg(1, 3, "rel.eng");
    repeat (HOLD) cycle("rel.engh");
    nrml_di = 4'b0110; jtag_di = 5'b10000;
    cfg(0, 0, "rel.acc");
    repeat (HOLD) cycle("rel.hold");
    cycle("rel.new");
    chk("rel.const", 64'(mux_do), 64'b10110);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      jtag_mode    = ($urandom_range(0, 9) == 0);
      nrml_di      = 4'($urandom);
      jtag_di      = 5'($urandom);
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_fail_en  = 1'($urandom);
      cfg_fail_idx = 2'($urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
